// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: run-control and termination monitor for NUM_CPU cores.
// Counts RUN cycles after start and stops on the first halt, exception or
// watchdog timeout. It latches the core that ended the run, the reason and the
// cycle on which the event was sampled.
// Optional feature macro: CPU_RUN_MON_TIMEOUT_EN (enables the watchdog).
module cpu_run_monitor #(
  parameter int unsigned NUM_CPU = 1,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100000,
  localparam int unsigned EV_W   = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               start,
  input  logic               clear,
  input  logic [NUM_CPU-1:0] halt,
  input  logic [NUM_CPU-1:0] exception,
  output logic               running,
  output logic               done,
  output logic               done_pulse,
  output logic               done_halt,
  output logic               done_exc,
  output logic               done_timeout,
  output logic [EV_W-1:0]    event_cpu,
  output logic [CNT_W-1:0]   event_cycle,
  output logic [CNT_W-1:0]   cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Reject illegal parameterisations at elaboration
  if (NUM_CPU < 1 || NUM_CPU > 16) begin : g_bad_num_cpu
    $error("cpu_run_monitor: NUM_CPU must be 1..16");
  end
  if (TIMEOUT < 1 || 64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_timeout
    $error("cpu_run_monitor: TIMEOUT must be 1..2^CNT_W-1");
  end

`ifdef CPU_RUN_MON_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);
`endif

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   ev_cycle_d;
  logic [EV_W-1:0]    ev_cpu_d;
  logic               halt_d;
  logic               exc_d;
  logic               to_d;
  logic               pulse_d;

  logic [NUM_CPU-1:0] term_c;
  logic               win_c;
  logic [EV_W-1:0]    win_idx_c;
  logic               win_halt_c;

  assign term_c = halt | exception;

  // Lowest-index terminating core wins; halt outranks exception on that core
  always_comb begin
    win_c      = 1'b0;
    win_idx_c  = '0;
    win_halt_c = 1'b0;
    for (int i = NUM_CPU - 1; i >= 0; i--) begin
      if (term_c[i]) begin
        win_c      = 1'b1;
        win_idx_c  = EV_W'(i);
        win_halt_c = halt[i];
      end
    end
  end

  // Next-state and next-status logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cycle_count;
    ev_cycle_d = event_cycle;
    ev_cpu_d   = event_cpu;
    halt_d     = done_halt;
    exc_d      = done_exc;
    to_d       = done_timeout;
    pulse_d    = 1'b0;

    if (clear) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      ev_cycle_d = '0;
      ev_cpu_d   = '0;
      halt_d     = 1'b0;
      exc_d      = 1'b0;
      to_d       = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end
        S_RUN: begin
          if (win_c) begin
            state_d    = S_DONE;
            pulse_d    = 1'b1;
            ev_cpu_d   = win_idx_c;
            ev_cycle_d = cycle_count;
            halt_d     = win_halt_c;
            exc_d      = ~win_halt_c;
`ifdef CPU_RUN_MON_TIMEOUT_EN
          end else if (cycle_count == TO_LAST) begin
            state_d    = S_DONE;
            pulse_d    = 1'b1;
            cnt_d      = TO_VAL;
            ev_cycle_d = TO_VAL;
            ev_cpu_d   = '0;
            to_d       = 1'b1;
          end else begin
            cnt_d = cycle_count + CNT_W'(1);
          end
`else
          end else if (cycle_count != '1) begin
            // Saturate rather than wrap when no watchdog is present
            cnt_d = cycle_count + CNT_W'(1);
          end
`endif
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= S_IDLE;
      running      <= 1'b0;
      done         <= 1'b0;
      done_pulse   <= 1'b0;
      done_halt    <= 1'b0;
      done_exc     <= 1'b0;
      done_timeout <= 1'b0;
      event_cpu    <= '0;
      event_cycle  <= '0;
      cycle_count  <= '0;
    end else begin
      state_q      <= state_d;
      running      <= (state_d == S_RUN);
      done         <= (state_d == S_DONE);
      done_pulse   <= pulse_d;
      done_halt    <= halt_d;
      done_exc     <= exc_d;
      done_timeout <= to_d;
      event_cpu    <= ev_cpu_d;
      event_cycle  <= ev_cycle_d;
      cycle_count  <= cnt_d;
    end
  end

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Synthesizable run-control and termination monitor for one or more CPU cores.
- Counts execution cycles after a start request and watches each core's halt and exception lines.
- Stops on the first halt, exception or watchdog timeout, and latches which core ended the run, why, and on which cycle.
- Sits beside the cpu2-class cores in SoC and bench builds, replacing ad-hoc cycle counting and halt/exception handling.

Parameters:
- NUM_CPU, 1, number of monitored cores (1..16).
- CNT_W, 32, width of the cycle counters.
- TIMEOUT, 100000, watchdog limit in RUN cycles; must satisfy 1 <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk  input  1  clock, all logic on the rising edge.
- rst_  input  1  asynchronous active-low reset.
- start  input  1  begin a run; honoured only in IDLE.
- clear  input  1  synchronous return to IDLE; clears all status and counters.
- halt  input  NUM_CPU  per-core halt request, level.
- exception  input  NUM_CPU  per-core illegal-instruction indication, level.
- running  output  1  high while in RUN.
- done  output  1  high while in DONE.
- done_pulse  output  1  one-cycle pulse on the cycle DONE is entered.
- done_halt  output  1  run ended by a halt.
- done_exc  output  1  run ended by an exception (with no halt on the same core and cycle).
- done_timeout  output  1  run ended by the watchdog.
- event_cpu  output  max(1,$clog2(NUM_CPU))  index of the core that ended the run.
- event_cycle  output  CNT_W  value of cycle_count when the terminating event was sampled.
- cycle_count  output  CNT_W  cycles spent in RUN.

Behaviour:
- Reset (rst_ low, asynchronous):
  - state = IDLE.
  - All outputs 0: running, done, done_pulse, done_halt, done_exc, done_timeout, event_cpu, event_cycle, cycle_count.
- States are IDLE, RUN and DONE.
- clear has priority over every other event. In any state, clear=1 at a posedge gives:
  - state = IDLE next cycle;
  - all status outputs and counters = 0;
  - start on the same edge is ignored.
- IDLE:
  - start=1 -> RUN next cycle, cycle_count=0.
  - halt and exception are ignored.
- RUN, evaluated each posedge:
  - A core is terminating if halt[i]=1 or exception[i]=1.
  - If any core is terminating, the lowest-index terminating core i wins:
    - event_cpu = i;
    - event_cycle = cycle_count (pre-increment);
    - if halt[i]=1 then done_halt=1, else done_exc=1. Halt outranks exception on the same core; done_halt and done_exc are never both 1.
    - state -> DONE, done_pulse=1 for exactly one cycle, cycle_count holds.
  - Otherwise, if cycle_count == TIMEOUT-1 (and the timeout feature is compiled in):
    - cycle_count = TIMEOUT, event_cycle = TIMEOUT, event_cpu = 0;
    - done_timeout=1, state -> DONE, done_pulse=1.
  - Otherwise cycle_count += 1.
  - A halt/exception on the same edge as the timeout wins over the timeout.
- DONE:
  - All status outputs hold.
  - start is ignored; only clear or reset leaves DONE.
  - halt and exception are ignored.
- Registered outputs:
  - running = (state==RUN) and done = (state==DONE), both registered with the state.
  - done_pulse is high only on the first DONE cycle.
- Reset asserted mid-run aborts immediately; no done_pulse is produced.
- An X or unknown on halt or exception does not need handling; the inputs are assumed driven after reset.

Optional Feature:
- Macro: CPU_RUN_MON_TIMEOUT_EN.
- Defined:
  - watchdog active as described;
  - done_timeout can assert.
- Undefined:
  - no watchdog comparator;
  - done_timeout tied to 0;
  - cycle_count saturates at 2^CNT_W-1 and does not wrap, so RUN continues until halt, exception or clear.

Test Plan:
- Reset then start, NUM_CPU=1, halt asserted on the 10th RUN cycle (cycle_count=9):
  - done_pulse for 1 cycle;
  - done_halt=1, event_cycle=9, event_cpu=0, cycle_count stays 9.
- NUM_CPU=4, exception[2] and exception[3] rise together at cycle_count=5:
  - done_exc=1, event_cpu=2, event_cycle=5, done_halt=0.
- halt[1]=1 and exception[1]=1 on the same cycle, with exception[0]=1 also high:
  - event_cpu=0, done_exc=1;
  - repeat with exception[0]=0 -> event_cpu=1, done_halt=1, done_exc=0.
- With CPU_RUN_MON_TIMEOUT_EN, TIMEOUT=20, no events:
  - DONE after 20 RUN cycles, done_timeout=1, cycle_count=20, event_cycle=20;
  - halt on the 20th cycle instead -> done_halt=1, event_cycle=19.
- In DONE, assert start, then clear and start together:
  - start alone has no effect;
  - clear+start -> IDLE with all outputs 0;
  - a following start enters RUN with cycle_count=0.
- Drop rst_ while in RUN at cycle_count=7, asynchronously between edges:
  - all outputs 0 immediately, no done_pulse;
  - after release, state IDLE until start.
